// File: rtl/vga_scope_display.sv
// Pipelined VGA raster engine: timing generator, N X/Y cursors, waveform overlay and grid.
// Define VGA_SCOPE_GRID_EN to draw the grid and border; otherwise those pixels stay black.
module vga_scope_display #(
  parameter int   H_ACTIVE   = 800,
  parameter int   H_FP       = 56,
  parameter int   H_SYNC     = 120,
  parameter int   H_BP       = 64,
  parameter int   V_ACTIVE   = 600,
  parameter int   V_FP       = 37,
  parameter int   V_SYNC     = 6,
  parameter int   V_BP       = 23,
  parameter logic HS_POL     = 1'b1,
  parameter logic VS_POL     = 1'b1,
  parameter int   CW         = 11,
  parameter int   NCUR       = 2,
  parameter int   COLOR_W    = 8,
  parameter int   GRID_PITCH = 50
) (
  input  logic                 clk50,
  input  logic                 rst,
  input  logic                 cursor_x_en,
  input  logic                 cursor_y_en,
  input  logic [NCUR*CW-1:0]   cursor_x,
  input  logic [NCUR*CW-1:0]   cursor_y,
  output logic [CW-1:0]        pix_x,
  output logic [CW-1:0]        pix_y,
  input  logic                 wave_hit,
  output logic                 frame_start,
  output logic                 hsync_out,
  output logic                 vsync_out,
  output logic [COLOR_W-1:0]   red_out,
  output logic [COLOR_W-1:0]   green_out,
  output logic [COLOR_W-1:0]   blue_out
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_EDGE = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] V_EDGE = CW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);

  // 0x40 on an 8-bit channel, i.e. the second MSB set, at any channel width
  function automatic logic [COLOR_W-1:0] grey_level();
    logic [COLOR_W-1:0] g;
    g = '0;
    g[COLOR_W-2] = 1'b1;
    return g;
  endfunction

  logic [CW-1:0]      h_cnt_p0, v_cnt_p0;
  logic               h_wrap_p0, v_wrap_p0;
  logic               vld_p0, hs_p0, vs_p0, cur_hit_p0, grid_hit_p0;
  logic               sh_x_en, sh_y_en;
  logic [NCUR*CW-1:0] sh_x, sh_y;
  logic               vld_p1, hs_p1, vs_p1, cur_p1, grid_p1;
  logic [COLOR_W-1:0] red_p1, green_p1, blue_p1;

  // ---- stage 0: raster counters, cursor shadow, per-pixel hit decode ----
  assign h_wrap_p0 = (h_cnt_p0 == H_LAST);
  assign v_wrap_p0 = (v_cnt_p0 == V_LAST);

  always_ff @(posedge clk50) begin
    if (rst) begin
      h_cnt_p0 <= '0;
      v_cnt_p0 <= '0;
    end else if (h_wrap_p0) begin
      h_cnt_p0 <= '0;
      v_cnt_p0 <= v_wrap_p0 ? '0 : v_cnt_p0 + 1'b1;
    end else begin
      h_cnt_p0 <= h_cnt_p0 + 1'b1;
    end
  end

  // Cursors only move at the start of vblank so a frame is never drawn half old, half new
  always_ff @(posedge clk50) begin
    if (rst) begin
      sh_x_en <= 1'b0;
      sh_y_en <= 1'b0;
      sh_x    <= '0;
      sh_y    <= '0;
    end else if (h_cnt_p0 == '0 && v_cnt_p0 == V_ACT) begin
      sh_x_en <= cursor_x_en;
      sh_y_en <= cursor_y_en;
      sh_x    <= cursor_x;
      sh_y    <= cursor_y;
    end
  end

  assign pix_x       = h_cnt_p0;
  assign pix_y       = v_cnt_p0;
  assign frame_start = !rst && h_cnt_p0 == '0 && v_cnt_p0 == '0;
  assign vld_p0      = (h_cnt_p0 < H_ACT) && (v_cnt_p0 < V_ACT);
  assign hs_p0       = (h_cnt_p0 >= HS_BEG && h_cnt_p0 < HS_END) ? HS_POL : ~HS_POL;
  assign vs_p0       = (v_cnt_p0 >= VS_BEG && v_cnt_p0 < VS_END) ? VS_POL : ~VS_POL;

  always_comb begin
    cur_hit_p0 = 1'b0;
    for (int i = 0; i < NCUR; i++) begin
      if (sh_x_en && h_cnt_p0 < H_ACT && h_cnt_p0 == sh_x[i*CW +: CW]) cur_hit_p0 = 1'b1;
      if (sh_y_en && v_cnt_p0 < V_ACT && v_cnt_p0 == sh_y[i*CW +: CW]) cur_hit_p0 = 1'b1;
    end
  end

`ifdef VGA_SCOPE_GRID_EN
  localparam int GW = (GRID_PITCH > 1) ? $clog2(GRID_PITCH) : 1;
  localparam logic [GW-1:0] G_LAST = GW'(GRID_PITCH - 1);

  logic [GW-1:0] h_grid_p0, v_grid_p0;

  // Phase counters track position within the grid pitch without a divider
  always_ff @(posedge clk50) begin
    if (rst) begin
      h_grid_p0 <= '0;
      v_grid_p0 <= '0;
    end else if (h_wrap_p0) begin
      h_grid_p0 <= '0;
      if (v_wrap_p0 || v_grid_p0 == G_LAST) v_grid_p0 <= '0;
      else v_grid_p0 <= v_grid_p0 + 1'b1;
    end else begin
      h_grid_p0 <= (h_grid_p0 == G_LAST) ? '0 : h_grid_p0 + 1'b1;
    end
  end

  assign grid_hit_p0 = (h_grid_p0 == '0) || (v_grid_p0 == '0) ||
                       (h_cnt_p0 == H_EDGE) || (v_cnt_p0 == V_EDGE);
`else
  assign grid_hit_p0 = 1'b0;
`endif

  // ---- stage 1: registered decode, merged with the returning wave_hit ----
  always_ff @(posedge clk50) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      hs_p1   <= ~HS_POL;
      vs_p1   <= ~VS_POL;
      cur_p1  <= 1'b0;
      grid_p1 <= 1'b0;
    end else begin
      vld_p1  <= vld_p0;
      hs_p1   <= hs_p0;
      vs_p1   <= vs_p0;
      cur_p1  <= cur_hit_p0;
      grid_p1 <= grid_hit_p0;
    end
  end

  always_comb begin
    red_p1   = '0;
    green_p1 = '0;
    blue_p1  = '0;
    if (vld_p1) begin
      if (cur_p1) begin
        red_p1   = '1;
        green_p1 = '1;
      end else if (wave_hit) begin
        green_p1 = '1;
      end else if (grid_p1) begin
        red_p1   = grey_level();
        green_p1 = grey_level();
        blue_p1  = grey_level();
      end
    end
  end

  // ---- stage 2: output registers, syncs and colour leave together ----
  always_ff @(posedge clk50) begin
    if (rst) begin
      red_out   <= '0;
      green_out <= '0;
      blue_out  <= '0;
      hsync_out <= ~HS_POL;
      vsync_out <= ~VS_POL;
    end else begin
      red_out   <= red_p1;
      green_out <= green_p1;
      blue_out  <= blue_p1;
      hsync_out <= hs_p1;
      vsync_out <= vs_p1;
    end
  end

endmodule

// File: tb/tb_vga_scope_display.sv
// Randomised bench for vga_scope_display on a shrunken raster; every cycle's outputs are
// compared with a per-pixel reference model evaluated from raster coordinates.
module tb_vga_scope_display;

  localparam int   HA = 40, HFP = 4, HSY = 6, HBP = 4;
  localparam int   VA = 30, VFP = 2, VSY = 3, VBP = 2;
  localparam int   HT = HA + HFP + HSY + HBP;
  localparam int   VT = VA + VFP + VSY + VBP;
  localparam int   FRAME = HT * VT;
  localparam logic HS_POL = 1'b1, VS_POL = 1'b0;
  localparam int   CW = 11, NCUR = 2, COLOR_W = 8, GP = 10;
  localparam logic [25:0] BLANK = {~HS_POL, ~VS_POL, 24'h0};

  logic                 clk50 = 1'b0;
  logic                 rst;
  logic                 cursor_x_en, cursor_y_en;
  logic [NCUR*CW-1:0]   cursor_x, cursor_y;
  logic [CW-1:0]        pix_x, pix_y;
  logic                 wave_hit;
  logic                 frame_start, hsync_out, vsync_out;
  logic [COLOR_W-1:0]   red_out, green_out, blue_out;

  vga_scope_display #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .CW(CW), .NCUR(NCUR),
    .COLOR_W(COLOR_W), .GRID_PITCH(GP)
  ) dut (
    .clk50(clk50), .rst(rst),
    .cursor_x_en(cursor_x_en), .cursor_y_en(cursor_y_en),
    .cursor_x(cursor_x), .cursor_y(cursor_y),
    .pix_x(pix_x), .pix_y(pix_y), .wave_hit(wave_hit),
    .frame_start(frame_start), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .red_out(red_out), .green_out(green_out), .blue_out(blue_out)
  );

  always #10 clk50 = ~clk50;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int          k;
  int          prev_h, prev_v;
  int unsigned wseed;
  bit          in_xen, in_yen, sh_xen, sh_yen;
  int          in_x[NCUR], in_y[NCUR], sh_x[NCUR], sh_y[NCUR];
  logic [25:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s k=%0d: got %h expected %h", tag, k, obs, exp);
    end
  endtask

  function automatic logic wave_fn(int h, int v);
    return (h == v) || ((((h * 13) ^ (v * 7) ^ int'(wseed)) & 15) == 0);
  endfunction

  function automatic logic [25:0] exp_pix(int h, int v);
    logic       hs, vs, act, cur, grid;
    logic [7:0] r, g, b;
    hs  = (h >= HA + HFP && h < HA + HFP + HSY) ? HS_POL : ~HS_POL;
    vs  = (v >= VA + VFP && v < VA + VFP + VSY) ? VS_POL : ~VS_POL;
    act = (h < HA) && (v < VA);
    cur = 1'b0;
    for (int i = 0; i < NCUR; i++) begin
      if (sh_xen && sh_x[i] == h) cur = 1'b1;
      if (sh_yen && sh_y[i] == v) cur = 1'b1;
    end
`ifdef VGA_SCOPE_GRID_EN
    grid = (h % GP == 0) || (v % GP == 0) || (h == HA - 1) || (v == VA - 1);
`else
    grid = 1'b0;
`endif
    r = 8'h00; g = 8'h00; b = 8'h00;
    if (act) begin
      if (cur) begin r = 8'hff; g = 8'hff; end
      else if (wave_fn(h, v)) g = 8'hff;
      else if (grid) begin r = 8'h40; g = 8'h40; b = 8'h40; end
    end
    return {hs, vs, r, g, b};
  endfunction

  task automatic model_reset();
    k = 0;
    exp_q.delete();
    exp_q.push_back(BLANK);
    exp_q.push_back(BLANK);
    sh_xen = 1'b0;
    sh_yen = 1'b0;
    for (int i = 0; i < NCUR; i++) begin sh_x[i] = 0; sh_y[i] = 0; end
  endtask

  function automatic int rand_pos(int lim);
    return ($urandom_range(0, 9) == 0) ? 900 : int'($urandom_range(0, lim - 1));
  endfunction

  task automatic new_cursors();
    in_xen = ($urandom_range(0, 3) != 0);
    in_yen = ($urandom_range(0, 3) != 0);
    for (int i = 0; i < NCUR; i++) begin
      in_x[i] = rand_pos(HT);
      in_y[i] = rand_pos(VT);
    end
    if ($urandom_range(0, 3) == 0) in_x[1] = in_x[0];
    if ($urandom_range(0, 3) == 0) in_y[1] = in_y[0];
  endtask

  // One clock cycle: drive inputs, check stage-0 outputs and the pixel from two cycles ago
  task automatic step(input logic rst_v, input bit chg);
    int h, v;
    h = k % HT;
    v = (k / HT) % VT;
    @(posedge clk50);
    #1;
    rst = rst_v;
    if (chg) new_cursors();
    cursor_x_en = in_xen;
    cursor_y_en = in_yen;
    for (int i = 0; i < NCUR; i++) begin
      cursor_x[i*CW +: CW] = CW'(in_x[i]);
      cursor_y[i*CW +: CW] = CW'(in_y[i]);
    end
    wave_hit = wave_fn(prev_h, prev_v);
    exp_q.push_back(exp_pix(h, v));
    @(negedge clk50);
    check("pix_xy", {pix_x, pix_y}, {CW'(h), CW'(v)});
    check("frame_start", frame_start, (!rst_v && h == 0 && v == 0));
    check("video", {hsync_out, vsync_out, red_out, green_out, blue_out}, exp_q.pop_front());
    prev_h = h;
    prev_v = v;
    if (rst_v) begin
      model_reset();
    end else begin
      if (h == 0 && v == VA) begin
        sh_xen = in_xen;
        sh_yen = in_yen;
        for (int i = 0; i < NCUR; i++) begin sh_x[i] = in_x[i]; sh_y[i] = in_y[i]; end
      end
      k++;
    end
  endtask

  initial begin
    rst         = 1'b1;
    wave_hit    = 1'b0;
    cursor_x_en = 1'b0;
    cursor_y_en = 1'b0;
    cursor_x    = '0;
    cursor_y    = '0;
    in_xen      = 1'b0;
    in_yen      = 1'b0;
    for (int i = 0; i < NCUR; i++) begin in_x[i] = 0; in_y[i] = 0; end
    wseed  = $urandom;
    prev_h = 0;
    prev_v = 0;
    model_reset();

    repeat (3) step(1'b1, 1'b0);

    for (int n = 0; n < 2 * FRAME; n++)
      step(1'b0, (n == 0) || ($urandom_range(0, 399) == 0));

    // abandon a frame midway through the active area
    for (int n = 0; n < FRAME && !((k % HT) == HA / 2 && ((k / HT) % VT) == VA / 2); n++)
      step(1'b0, 1'b0);
    step(1'b1, 1'b0);

    for (int n = 0; n < 3 * FRAME; n++)
      step(1'b0, ($urandom_range(0, 299) == 0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
